// File: rtl/control_sequencer_if.sv
// Datapath control bus between the sequencer and the 32-bit bus datapath:
// IR and memory-ready come back from the datapath, register/bus/ALU controls go out.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zhi_out, Zlo_out, HIin, LOin, Read;
    logic [4:0]  opcode;
    logic [15:0] Rin;
    logic [15:0] Rout;

    modport master (
        input  ir, mem_ready,
        output PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin,
               Yin, Zin, Zhi_out, Zlo_out, HIin, LOin, Read,
               opcode, Rin, Rout
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin,
               Yin, Zin, Zhi_out, Zlo_out, HIin, LOin, Read,
               opcode, Rin, Rout
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore fetch/execute sequencer for the bus-based datapath.
// Controls are decoded from the T-state and the IR fields only.
//
// state  | meaning
// IDLE   | stopped between instructions, waits for run
// T0     | PC -> MAR, Z <- PC + 1
// T1     | PC <- Z, memory read into MDR (held until mem_ready)
// T2     | MDR -> IR
// T3     | decode; first operand -> Y (or halt / illegal)
// T4     | second operand through ALU into Z
// T5     | Z low -> Rd (ALU class, retire) or LO (mul/div)
// T6     | Z high -> HI, retire (mul/div only)
// HALT   | halted until clear
module control_sequencer #(
    parameter int         CNT_W   = 16,
    parameter logic [4:0] OP_HALT = 5'b11011,
    parameter logic [4:0] OP_MUL  = 5'b01110,
    parameter logic [4:0] OP_DIV  = 5'b01111
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 run,
    control_sequencer_if.master  bus,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instr_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t     state, state_next;
    logic       retire;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       alu_class, md_class;
    logic       unused_ir;

    assign op        = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    assign alu_class = (op <= 5'b01011) && (op != OP_HALT);
    assign md_class  = !alu_class && (op != OP_HALT) &&
                       ((op == OP_MUL) || (op == OP_DIV));

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        bus.PCout   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.PCin    = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zhi_out = 1'b0;
        bus.Zlo_out = 1'b0;
        bus.HIin    = 1'b0;
        bus.LOin    = 1'b0;
        bus.Read    = 1'b0;
        bus.opcode  = 5'b0;
        bus.Rin     = 16'h0000;
        bus.Rout    = 16'h0000;

        case (state)
            S_IDLE: begin
                if (run) state_next = S_T0;
            end
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.MARin  = 1'b1;
                bus.Zin    = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                // Rewriting PC from an unchanged Z while stalled is harmless.
                bus.Zlo_out = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready) state_next = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (op == OP_HALT) begin
                    state_next = S_HALT;
                end else if (alu_class) begin
                    bus.Rout   = onehot(rb);
                    bus.Yin    = 1'b1;
                    state_next = S_T4;
                end else if (md_class) begin
                    bus.Rout   = onehot(ra);
                    bus.Yin    = 1'b1;
                    state_next = S_T4;
                end else begin
                    illegal    = 1'b1;
                    state_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                bus.Zin    = 1'b1;
                bus.opcode = op;
                bus.Rout   = md_class ? onehot(rb) : onehot(rc);
                state_next = S_T5;
            end
            S_T5: begin
                bus.Zlo_out = 1'b1;
                if (md_class) begin
                    bus.LOin   = 1'b1;
                    state_next = S_T6;
                end else begin
                    bus.Rin    = onehot(ra);
                    retire     = 1'b1;
                    state_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                bus.Zhi_out = 1'b1;
                bus.HIin    = 1'b1;
                retire      = 1'b1;
                state_next  = run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: an instruction-level model
// plans per-cycle inputs and expected controls; a monitor compares every cycle.
module tb_control_sequencer;

    localparam int         CNT_W   = 4;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;

    localparam int C_PCOUT = 13, C_INCPC = 12, C_PCIN = 11, C_MARIN = 10;
    localparam int C_MDRIN = 9, C_MDROUT = 8, C_IRIN = 7, C_YIN = 6, C_ZIN = 5;
    localparam int C_ZHI = 4, C_ZLO = 3, C_HIIN = 2, C_LOIN = 1, C_READ = 0;

    logic             clock = 1'b0;
    logic             clear = 1'b0;
    logic             run   = 1'b0;
    logic             halted, illegal;
    logic [CNT_W-1:0] instr_count;

    control_sequencer_if bus();

    control_sequencer #(
        .CNT_W(CNT_W), .OP_HALT(OP_HALT), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .run         (run),
        .bus         (bus),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        clr;
        logic        run;
        logic        mem_ready;
        logic [31:0] ir;
    } stim_t;

    typedef struct packed {
        logic [13:0]      ctl;
        logic [4:0]       opcode;
        logic [15:0]      rin;
        logic [15:0]      rout;
        logic             halted;
        logic             illegal;
        logic [CNT_W-1:0] count;
    } exp_t;

    stim_t plan_s[$];
    exp_t  plan_e[$];
    exp_t  sb_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_mon    = 0;
    int          n_total  = 0;
    int          m_count  = 0;
    bit          m_idle   = 1'b1;
    logic [31:0] cur_ir   = 32'h0;
    int          g_k, g_abort;
    bit          g_ab;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t base();
        exp_t e;
        e = '0;
        e.count = m_count[CNT_W-1:0];
        return e;
    endfunction

    task automatic emit(input logic c, input logic r, input logic mr, input exp_t e);
        stim_t s;
        s.clr = c; s.run = r; s.mem_ready = mr; s.ir = cur_ir;
        plan_s.push_back(s);
        plan_e.push_back(e);
    endtask

    task automatic do_clear();
        exp_t e;
        e = '0;
        emit(1'b0, rbit(), rbit(), e);
        m_count = 0;
        m_idle  = 1'b1;
    endtask

    task automatic idle_lead();
        int n;
        if (m_idle) begin
            n = $urandom_range(0, 2);
            repeat (n) emit(1'b1, 1'b0, rbit(), base());
            emit(1'b1, 1'b1, rbit(), base());
            m_idle = 1'b0;
        end
    endtask

    task automatic step(input exp_t e, input logic r, input logic mr);
        if (g_k == g_abort) begin
            do_clear();
            g_ab = 1'b1;
        end else begin
            emit(1'b1, r, mr, e);
        end
        g_k++;
    endtask

    function automatic void retire_done(input bit run_end);
        m_count = (m_count + 1) % (1 << CNT_W);
        m_idle  = !run_end;
    endfunction

    // One instruction as seen from outside: fetch, optional stall, decode class.
    task automatic instr(input logic [31:0] iw, input int stall, input bit run_end,
                         input int abort_at);
        exp_t       e;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         alu, md;
        op = iw[31:27]; ra = iw[26:23]; rb = iw[22:19]; rc = iw[18:15];
        alu = (op <= 5'd11);
        md  = (op == OP_MUL) || (op == OP_DIV);
        g_k = 0; g_abort = abort_at; g_ab = 1'b0;
        idle_lead();

        e = base();
        e.ctl[C_PCOUT] = 1'b1; e.ctl[C_INCPC] = 1'b1; e.ctl[C_MARIN] = 1'b1; e.ctl[C_ZIN] = 1'b1;
        step(e, rbit(), rbit()); if (g_ab) return;

        for (int s = 0; s <= stall; s++) begin
            e = base();
            e.ctl[C_ZLO] = 1'b1; e.ctl[C_PCIN] = 1'b1; e.ctl[C_READ] = 1'b1; e.ctl[C_MDRIN] = 1'b1;
            step(e, rbit(), (s == stall)); if (g_ab) return;
        end

        cur_ir = iw;
        e = base();
        e.ctl[C_MDROUT] = 1'b1; e.ctl[C_IRIN] = 1'b1;
        step(e, rbit(), rbit()); if (g_ab) return;

        e = base();
        if (op == OP_HALT) begin
            step(e, rbit(), rbit()); if (g_ab) return;
            for (int h = 0; h < 20; h++) begin
                e = base();
                e.halted = 1'b1;
                emit(1'b1, 1'b1, rbit(), e);
            end
            do_clear();
            return;
        end else if (alu) begin
            e.rout = 16'h0001 << rb; e.ctl[C_YIN] = 1'b1;
        end else if (md) begin
            e.rout = 16'h0001 << ra; e.ctl[C_YIN] = 1'b1;
        end else begin
            e.illegal = 1'b1;
            step(e, run_end, rbit()); if (g_ab) return;
            m_idle = !run_end;
            return;
        end
        step(e, rbit(), rbit()); if (g_ab) return;

        e = base();
        e.ctl[C_ZIN] = 1'b1; e.opcode = op;
        e.rout = alu ? (16'h0001 << rc) : (16'h0001 << rb);
        step(e, rbit(), rbit()); if (g_ab) return;

        e = base();
        e.ctl[C_ZLO] = 1'b1;
        if (alu) begin
            e.rin = 16'h0001 << ra;
            step(e, run_end, rbit()); if (g_ab) return;
            retire_done(run_end);
            return;
        end
        e.ctl[C_LOIN] = 1'b1;
        step(e, rbit(), rbit()); if (g_ab) return;

        e = base();
        e.ctl[C_ZHI] = 1'b1; e.ctl[C_HIIN] = 1'b1;
        step(e, run_end, rbit()); if (g_ab) return;
        retire_done(run_end);
    endtask

    task automatic random_instr();
        int          r;
        logic [4:0]  op;
        logic [31:0] rv;
        int          ab;
        r  = $urandom_range(0, 9);
        rv = $urandom;
        if (r < 6) begin
            op = 5'($urandom_range(0, 11));
        end else if (r < 8) begin
            op = (r == 6) ? OP_MUL : OP_DIV;
        end else begin
            do op = 5'($urandom_range(12, 31));
            while (op == OP_HALT || op == OP_MUL || op == OP_DIV);
        end
        ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 6)) : -1;
        instr({op, rv[26:0]}, $urandom_range(0, 3), ($urandom_range(0, 4) != 0), ab);
    endtask

    initial begin
        stim_t s;
        bus.ir = 32'h0;
        bus.mem_ready = 1'b0;

        repeat (3) do_clear();
        emit(1'b1, 1'b0, 1'b0, base());
        instr(32'h28918000, 0, 1'b1, -1);
        instr(32'h28918000, 3, 1'b1, -1);
        instr(32'h72280000, 0, 1'b1, -1);
        instr(32'hF8000000, 0, 1'b1, -1);
        instr(32'h28918000, 0, 1'b0, -1);
        emit(1'b1, 1'b0, 1'b1, base());
        emit(1'b1, 1'b0, 1'b1, base());
        instr(32'h28918000, 0, 1'b1, 4);
        for (int i = 0; i < 17; i++) instr(32'h28918000, 0, 1'b1, -1);
        for (int i = 0; i < 40; i++) random_instr();
        instr(32'hD8000000, 1, 1'b1, -1);
        instr(32'h72280000, 2, 1'b0, -1);
        emit(1'b1, 1'b0, 1'b0, base());

        n_total = plan_s.size();
        while (plan_s.size() > 0) begin
            @(posedge clock);
            #1;
            s = plan_s.pop_front();
            clear         = s.clr;
            run           = s.run;
            bus.mem_ready = s.mem_ready;
            bus.ir        = s.ir;
            sb_q.push_back(plan_e.pop_front());
        end
        @(posedge clock);
        @(posedge clock);
        n_checks++;
        if (n_mon != n_total) begin
            n_fail++;
            $display("FAIL scoreboard_drain: compared %0d cycles, required %0d", n_mon, n_total);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        exp_t exp_v, act;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                act.ctl = {bus.PCout, bus.IncPC, bus.PCin, bus.MARin, bus.MDRin, bus.MDRout,
                           bus.IRin, bus.Yin, bus.Zin, bus.Zhi_out, bus.Zlo_out, bus.HIin,
                           bus.LOin, bus.Read};
                act.opcode  = bus.opcode;
                act.rin     = bus.Rin;
                act.rout    = bus.Rout;
                act.halted  = halted;
                act.illegal = illegal;
                act.count   = instr_count;
                n_checks++;
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL cycle%0d: got ctl=%h op=%h rin=%h rout=%h halt=%b ill=%b cnt=%h, required ctl=%h op=%h rin=%h rout=%h halt=%b ill=%b cnt=%h",
                             n_mon, act.ctl, act.opcode, act.rin, act.rout, act.halted,
                             act.illegal, act.count, exp_v.ctl, exp_v.opcode, exp_v.rin,
                             exp_v.rout, exp_v.halted, exp_v.illegal, exp_v.count);
                end
                n_mon++;
            end
        end
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired Moore control unit that sequences the 32-bit bus-based datapath through instruction fetch and execute. It drives the datapath's register enables, bus-source selects, ALU opcode and memory read strobe one T-state per clock, decodes the register fields of IR, and supports a memory-ready handshake on fetch. It replaces hand-driven control in bring-up benches and is the top-level controller of the CPU.

## Interface
Parameters
- CNT_W, 16, width of retired-instruction counter
- OP_HALT, 5'b11011, halt opcode
- OP_MUL, 5'b01110, multiply opcode (HI/LO writeback)
- OP_DIV, 5'b01111, divide opcode (HI/LO writeback)

Ports
- clock  in  1  single system clock, all state changes on rising edge
- clear  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 = fetch/execute continuously, 0 = stop at next instruction boundary
- mem_ready  in  1  memory data valid on Mdatain this cycle
- ir  in  32  IR contents from datapath; opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
- PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zhi_out, Zlo_out, HIin, LOin, Read  out  1 each  datapath controls
- opcode  out  5  ALU operation select
- Rin  out  16  one-hot GPR write enables R0..R15
- Rout  out  16  one-hot GPR bus-drive selects R0..R15
- halted  out  1  1 while in HALT
- illegal  out  1  one-cycle pulse on unsupported opcode
- instr_count  out  CNT_W  retired instructions

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs decoded purely from state and ir (Moore); any control not listed for a state is 0.
- IDLE: all controls 0. run=1 -> T0.
- T0: PCout, IncPC, MARin, Zin. -> T1.
- T1: Zlo_out, PCin, Read, MDRin. mem_ready=0 -> stay in T1 (all four held; rewriting PC with unchanged Z is harmless). mem_ready=1 -> T2.
- T2: MDRout, IRin. -> T3.
- T3 (decode from ir, now valid):
  - opcode==OP_HALT -> HALT, no controls asserted in T3.
  - opcode in 00000..01011 (three-register ALU class): Rout[rb], Yin. -> T4.
  - opcode==OP_MUL/OP_DIV: Rout[ra], Yin. -> T4.
  - any other opcode: illegal=1, no controls. -> T0 if run else IDLE.
- T4: Zin, opcode=ir[31:27]; Rout[rc] for ALU class, Rout[rb] for mul/div. -> T5.
- T5: Zlo_out; ALU class: Rin[ra], retire; mul/div: LOin, -> T6.
- T6 (mul/div only): Zhi_out, HIin, retire.
- Retire: instr_count += 1 (wraps max->0); next state T0 if run=1, else IDLE. run is sampled only on retire, illegal, or in IDLE.
- HALT: halted=1, all controls 0, run ignored; exits only via clear.
- opcode output is 0 in every state except T4.
- Rin/Rout are always one-hot or zero; R0 is an ordinary register.

## Timing
- Reset (clear=0): state IDLE, instr_count 0, all outputs 0, immediately (async) and held while low. Deassertion mid-instruction abandons it; restart from IDLE, fetch at T0 again.
- Latency with mem_ready tied 1: ALU instruction 6 cycles T0..T5, mul/div 7 cycles; back-to-back instructions with no bubble.
- Each additional mem_ready=0 cycle in T1 adds exactly one cycle.
- instr_count updates on the clock edge leaving T5 (ALU) or T6 (mul/div).
- illegal high only during the single T3 cycle.

## Test plan
- run=1, ir=0x28918000 (op 00101, ra1 rb2 rc3), mem_ready=1 -> T3 Rout=0x0004 Yin; T4 Rout=0x0008 opcode=00101 Zin; T5 Rin=0x0002 Zlo_out; instr_count=1; next cycle T0 signals.
- Same, mem_ready=0 for 3 cycles in T1 -> Read/MDRin/PCin/Zlo_out held 4 cycles; instruction takes 9 cycles.
- ir=0x72280000 (mul, ra4 rb5) -> T3 Rout=0x0010; T4 Rout=0x0020 opcode=01110; T5 LOin+Zlo_out; T6 HIin+Zhi_out; count +1.
- ir=0xD8000000 -> after T3 halted=1, all controls 0 for 20 cycles with run=1; clear low -> IDLE, halted=0.
- ir=0xF8000000 -> illegal pulse one cycle in T3, next state T0, instr_count unchanged; run=0 at T5 of an ALU op -> IDLE, no further T0.
- clear low during T4 -> Zin, Rout, opcode to 0 before next edge; instr_count=0; preload count 0xFFFF then retire -> 0x0000.
